// File: rtl/posit_defines_es3.sv
// rtl/posit_defines_es3.sv - shared constants and stage types for the posit<32,3> round/pack path
package posit_defines_es3;

  localparam int ES         = 3;
  localparam int ABITS      = 32;
  localparam int FRAC_BITS  = ABITS - 1;
  localparam int SCALE_BITS = 9;
  localparam int POSIT_SERIALIZED_WIDTH_SUM_ES3 = 1 + SCALE_BITS + FRAC_BITS + 2;

  localparam int NBITS_ES3 = 32;
  localparam logic [NBITS_ES3-1:0] MAXPOS_ES3 = 32'h7FFF_FFFF;
  localparam logic [NBITS_ES3-1:0] MINPOS_ES3 = 32'h0000_0001;
  localparam logic [NBITS_ES3-1:0] NAR_ES3    = 32'h8000_0000;
  localparam int SCALE_MAX_ES3 = 240;

  // Alignment window: {regime seed(2), e, fraction} followed by enough zero padding
  // that the longest regime never pushes a set bit off the bottom.
  localparam int SHAMT_W   = SCALE_BITS - ES;
  localparam int ALIGN_PAD = NBITS_ES3;
  localparam int ALIGN_W   = 2 + ES + FRAC_BITS + ALIGN_PAD;

  typedef struct packed {
    logic                  sgn;
    logic [SCALE_BITS-1:0] scale;
    logic [FRAC_BITS-1:0]  fraction;
    logic                  inf;
    logic                  zero;
  } value_sum;

  typedef struct packed {
    logic                 sgn;
    logic                 nar;
    logic                 zero;
    logic                 cmax;
    logic                 cmin;
    logic                 fill;
    logic [SHAMT_W-1:0]   shamt;
    logic [ES-1:0]        exp;
    logic [FRAC_BITS-1:0] frac;
  } s1_t;

  typedef struct packed {
    logic                 sgn;
    logic                 nar;
    logic                 zero;
    logic [NBITS_ES3-2:0] mag;
  } s2_t;

endpackage

// File: rtl/shift_right.sv
// rtl/shift_right.sv - logical right shift with a selectable fill bit for the vacated MSBs
module shift_right #(
  parameter int WIDTH   = 68,
  parameter int SHAMT_W = 6
) (
  input  logic [WIDTH-1:0]   data_i,
  input  logic [SHAMT_W-1:0] shamt_i,
  input  logic               fill_i,
  output logic [WIDTH-1:0]   data_o
);

  logic [WIDTH-1:0] fill_mask;

  assign fill_mask = fill_i ? ~({WIDTH{1'b1}} >> shamt_i) : '0;
  assign data_o    = (data_i >> shamt_i) | fill_mask;

endmodule

// File: rtl/posit_round_pack_es3.sv
// rtl/posit_round_pack_es3.sv - three-stage round-to-nearest-even pack of an adder sum into posit<32,3>
module posit_round_pack_es3
  import posit_defines_es3::*;
(
  input  logic                                      clk,
  input  logic                                      reset_n,
  input  logic [POSIT_SERIALIZED_WIDTH_SUM_ES3-1:0] in_sum,
  input  logic                                      in_valid,
  output logic                                      in_ready,
  output logic [NBITS_ES3-1:0]                      out_posit,
  output logic                                      out_valid,
  input  logic                                      out_ready
);

  localparam int MAG_W = NBITS_ES3 - 1;
  localparam logic signed [SCALE_BITS-1:0] SCALE_HI = SCALE_BITS'(SCALE_MAX_ES3);
  localparam logic signed [SCALE_BITS-1:0] SCALE_LO = SCALE_BITS'(-SCALE_MAX_ES3);

  logic stall;
  logic v1_q, v2_q, out_valid_q;
  s1_t  s1_d, s1_q;
  s2_t  s2_d, s2_q;
  logic [NBITS_ES3-1:0] out_posit_d, out_posit_q;

  assign stall     = out_valid_q & ~out_ready;
  assign in_ready  = ~stall;
  assign out_valid = out_valid_q;
  assign out_posit = out_posit_q;

  value_sum                     sum_w;
  logic signed [SCALE_BITS-1:0] scale_w;
  logic [SHAMT_W-1:0]           k_w;

  assign sum_w   = value_sum'(in_sum);
  assign scale_w = $signed(sum_w.scale);
  assign k_w     = scale_w[SCALE_BITS-1:ES];

  // For k < 0 the regime is (-k) zeros then a one; seeding "01" and shifting by
  // -k-1 (== ~k) produces exactly that, mirroring the "10" seed shifted by k.
  always_comb begin
    s1_d       = '0;
    s1_d.sgn   = sum_w.sgn;
    s1_d.nar   = sum_w.inf;
    s1_d.zero  = sum_w.zero & ~sum_w.inf;
    s1_d.cmax  = scale_w > SCALE_HI;
    s1_d.cmin  = scale_w < SCALE_LO;
    s1_d.fill  = ~k_w[SHAMT_W-1];
    s1_d.shamt = k_w[SHAMT_W-1] ? ~k_w : k_w;
    s1_d.exp   = sum_w.scale[ES-1:0];
    s1_d.frac  = sum_w.fraction;
  end

  logic [ALIGN_W-1:0] align_in, aligned;

  assign align_in = {s1_q.fill, ~s1_q.fill, s1_q.exp, s1_q.frac, {ALIGN_PAD{1'b0}}};

  shift_right #(
    .WIDTH   (ALIGN_W),
    .SHAMT_W (SHAMT_W)
  ) u_align (
    .data_i  (align_in),
    .shamt_i (s1_q.shamt),
    .fill_i  (s1_q.fill),
    .data_o  (aligned)
  );

  logic [MAG_W-1:0] mag_raw;
  logic             guard, sticky, round_up;
  logic [MAG_W:0]   mag_sum;

  always_comb begin
    mag_raw  = aligned[ALIGN_W-1 -: MAG_W];
    guard    = aligned[ALIGN_W-MAG_W-1];
    sticky   = |aligned[ALIGN_W-MAG_W-2:0];
    round_up = guard & (mag_raw[0] | sticky);
    mag_sum  = {1'b0, mag_raw} + {{MAG_W{1'b0}}, round_up};
    s2_d      = '0;
    s2_d.sgn  = s1_q.sgn;
    s2_d.nar  = s1_q.nar;
    s2_d.zero = s1_q.zero;
    // A finite nonzero value must stay strictly between 0 and NaR.
    if (s1_q.cmax || mag_sum[MAG_W]) begin
      s2_d.mag = MAXPOS_ES3[MAG_W-1:0];
    end else if (s1_q.cmin || (mag_sum[MAG_W-1:0] == '0)) begin
      s2_d.mag = MINPOS_ES3[MAG_W-1:0];
    end else begin
      s2_d.mag = mag_sum[MAG_W-1:0];
    end
  end

  logic [NBITS_ES3-1:0] pos_w;

  always_comb begin
    pos_w = {1'b0, s2_q.mag};
    if (s2_q.nar) begin
      out_posit_d = NAR_ES3;
    end else if (s2_q.zero) begin
      out_posit_d = '0;
    end else if (s2_q.sgn) begin
      out_posit_d = ~pos_w + 1'b1;
    end else begin
      out_posit_d = pos_w;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      v1_q        <= 1'b0;
      v2_q        <= 1'b0;
      out_valid_q <= 1'b0;
      s1_q        <= '0;
      s2_q        <= '0;
      out_posit_q <= '0;
    end else if (!stall) begin
      v1_q        <= in_valid;
      s1_q        <= s1_d;
      v2_q        <= v1_q;
      s2_q        <= s2_d;
      out_valid_q <= v2_q;
      out_posit_q <= out_posit_d;
    end
  end

endmodule

// File: tb/tb_posit_round_pack_es3.sv
// tb/tb_posit_round_pack_es3.sv - bench for posit_round_pack_es3
module tb_posit_round_pack_es3;

  logic        clk;
  logic        reset_n;
  logic [42:0] in_sum;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] out_posit;
  logic        out_valid;
  logic        out_ready;

  int checks   = 0;
  int failures = 0;
  int n_out    = 0;
  int n_exp    = 0;

  logic        pv[3];
  logic [31:0] pp[3];

  posit_round_pack_es3 dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .in_sum    (in_sum),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_posit (out_posit),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  function automatic logic [42:0] mk(input logic sgn, input int scale, input logic [30:0] frac,
                                     input logic inf, input logic zero);
    return {sgn, 9'(scale), frac, inf, zero};
  endfunction

  function automatic logic [42:0] rnd_sum();
    logic [8:0]  sc;
    logic [30:0] fr;
    logic        inf, zr, sg;
    case ($urandom_range(0, 3))
      0:       sc = 9'(230 + int'($urandom_range(0, 20)));
      1:       sc = 9'(0 - int'($urandom_range(230, 250)));
      default: sc = 9'($urandom_range(0, 511));
    endcase
    fr  = 31'($urandom);
    inf = ($urandom_range(0, 15) == 0);
    zr  = ($urandom_range(0, 15) == 0);
    sg  = ($urandom_range(0, 1) == 1);
    return {sg, sc, fr, inf, zr};
  endfunction

  // Reference: write out regime, exponent and fraction as a bit string, take the
  // top 31 bits as magnitude, round to nearest even on the remainder.
  function automatic logic [31:0] ref_posit(input logic [42:0] s);
    logic        sgn, inf, zero;
    logic [30:0] frac;
    int          scale, k, e;
    bit          q[$];
    longint      mag;
    bit          guard, sticky;
    sgn   = s[42];
    scale = int'($signed(s[41:33]));
    frac  = s[32:2];
    inf   = s[1];
    zero  = s[0];
    if (inf) return 32'h8000_0000;
    if (zero) return 32'h0000_0000;
    if (scale > 240) begin
      mag = 64'h7FFF_FFFF;
    end else if (scale < -240) begin
      mag = 1;
    end else begin
      e = ((scale % 8) + 8) % 8;
      k = (scale - e) / 8;
      if (k >= 0) begin
        repeat (k + 1) q.push_back(1'b1);
        q.push_back(1'b0);
      end else begin
        repeat (-k) q.push_back(1'b0);
        q.push_back(1'b1);
      end
      for (int i = 2; i >= 0; i--) q.push_back(e[i]);
      for (int i = 30; i >= 0; i--) q.push_back(frac[i]);
      mag = 0;
      for (int i = 0; i < 31; i++) mag = mag * 2 + longint'(q[i]);
      guard  = q[31];
      sticky = 1'b0;
      for (int i = 32; i < q.size(); i++) sticky = sticky | q[i];
      if (guard && ((mag % 2 == 1) || sticky)) mag = mag + 1;
      if (mag > 64'h7FFF_FFFF) mag = 64'h7FFF_FFFF;
      if (mag == 0) mag = 1;
    end
    return sgn ? 32'(64'h1_0000_0000 - mag) : 32'(mag);
  endfunction

  // One clock: drive at the falling edge, sample 1ns later, advance the model.
  task automatic cycle(input logic v, input logic [42:0] s, input logic [31:0] exp_val,
                       input logic ordy, output logic acc);
    logic stall;
    in_valid  = v;
    in_sum    = s;
    out_ready = ordy;
    #1;
    chk1("out_valid", out_valid, pv[2]);
    if (pv[2]) chk("out_posit", out_posit, pp[2]);
    stall = pv[2] & ~ordy;
    chk1("in_ready", in_ready, !stall);
    if (out_valid && out_ready) n_out++;
    if (pv[2] && ordy) n_exp++;
    acc = v & ~stall;
    if (!stall) begin
      pv[2] = pv[1]; pp[2] = pp[1];
      pv[1] = pv[0]; pp[1] = pp[0];
      pv[0] = acc;   pp[0] = exp_val;
    end
    @(negedge clk);
  endtask

  task automatic beat(input logic [42:0] s, input logic [31:0] e);
    logic acc;
    cycle(1'b1, s, e, 1'b1, acc);
  endtask

  task automatic idle(input int n);
    logic acc;
    repeat (n) cycle(1'b0, '0, '0, 1'b1, acc);
  endtask

  task automatic model_clear();
    for (int i = 0; i < 3; i++) begin
      pv[i] = 1'b0;
      pp[i] = '0;
    end
  endtask

  initial begin
    logic        acc;
    logic        have;
    logic [42:0] cur;
    logic [42:0] burst[8];
    int          idx;

    model_clear();
    reset_n   = 1'b0;
    in_valid  = 1'b0;
    in_sum    = '0;
    out_ready = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk1("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_posit", out_posit, 32'h0000_0000);
    chk1("rst_in_ready", in_ready, 1'b1);
    @(negedge clk);
    reset_n = 1'b1;

    beat(mk(0, 0, 31'h0, 0, 0), 32'h4000_0000);
    beat(mk(1, 0, 31'h0, 0, 0), 32'hC000_0000);
    beat(mk(0, 8, 31'h0, 0, 0), 32'h6000_0000);
    beat(mk(0, -240, 31'h0, 0, 0), 32'h0000_0001);
    beat(mk(0, 250, 31'h0, 0, 0), 32'h7FFF_FFFF);
    beat(mk(0, 0, 31'h10, 0, 0), 32'h4000_0000);
    beat(mk(0, 0, 31'h30, 0, 0), 32'h4000_0002);
    beat(mk(1, 37, 31'h1A5A_5A5A, 1, 0), 32'h8000_0000);
    beat(mk(0, 100, 31'h7FFF_FFFF, 1, 1), 32'h8000_0000);
    beat(mk(1, -3, 31'h1234_5, 0, 1), 32'h0000_0000);
    beat(mk(1, 250, 31'h0, 0, 0), 32'h8000_0001);
    beat(mk(0, -241, 31'h7FFF_FFFF, 0, 0), 32'h0000_0001);
    beat(mk(0, 240, 31'h7FFF_FFFF, 0, 0), 32'h7FFF_FFFF);
    beat(mk(0, -1, 31'h0, 0, 0), 32'h3C00_0000);
    idle(4);

    // Back-to-back burst with the consumer stalling for four cycles mid-stream.
    for (int i = 0; i < 8; i++) burst[i] = rnd_sum();
    idx = 0;
    for (int c = 0; c < 40 && idx < 8; c++) begin
      cycle(1'b1, burst[idx], ref_posit(burst[idx]), !(c >= 3 && c < 7), acc);
      if (acc) idx++;
    end
    idle(5);

    have = 1'b0;
    cur  = '0;
    for (int c = 0; c < 300; c++) begin
      if (!have && ($urandom_range(0, 3) != 0)) begin
        cur  = rnd_sum();
        have = 1'b1;
      end
      cycle(have, cur, ref_posit(cur), ($urandom_range(0, 3) != 0), acc);
      if (acc) have = 1'b0;
    end
    idle(6);

    // Reset with three beats in flight.
    for (int i = 0; i < 3; i++) begin
      cur = rnd_sum();
      beat(cur, ref_posit(cur));
    end
    reset_n = 1'b0;
    #1;
    chk1("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_posit", out_posit, 32'h0000_0000);
    chk1("midrst_in_ready", in_ready, 1'b1);
    model_clear();
    @(negedge clk);
    in_valid = 1'b1;
    in_sum   = mk(0, 8, 31'h0, 0, 0);
    repeat (2) begin
      #1;
      chk1("inrst_out_valid", out_valid, 1'b0);
      @(negedge clk);
    end
    reset_n = 1'b1;
    idle(5);
    beat(mk(1, 8, 31'h0, 0, 0), 32'hA000_0000);
    idle(5);

    chk("delivered_count", n_out, n_exp);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
